// File: rtl/seg7_msg_pkg.sv
// Shared definitions for the 7-segment message player: character codes,
// segment glyphs, FSM state encoding and the default message table.
package seg7_msg_pkg;

   localparam logic [3:0] CH_BLANK = 4'd0;
   localparam logic [3:0] CH_H     = 4'd1;
   localparam logic [3:0] CH_E     = 4'd2;
   localparam logic [3:0] CH_L     = 4'd3;
   localparam logic [3:0] CH_O     = 4'd4;
   localparam logic [3:0] CH_P     = 4'd5;
   localparam logic [3:0] CH_R     = 4'd6;
   localparam logic [3:0] CH_G     = 4'd7;

   localparam logic [7:0] SEG_OFF = 8'h00;
   localparam logic [7:0] SEG_DP  = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHOW,
      ST_GAP,
      ST_END,
      ST_HOLD
   } player_state_t;

   // Registered display outputs, updated together from the next state.
   typedef struct packed {
      logic [7:0] seg;
      logic       done;
      logic       busy;
   } disp_t;

   // Segment order {dp,g,f,e,d,c,b,a}, active high.
   function automatic logic [7:0] glyph(input logic [3:0] code);
      logic [7:0] s;
      case (code)
         CH_H:    s = 8'h76;
         CH_E:    s = 8'h79;
         CH_L:    s = 8'h38;
         CH_O:    s = 8'h3F;
         CH_P:    s = 8'h73;
         CH_R:    s = 8'h50;
         CH_G:    s = 8'h3D;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   // Messages beyond the table, and slots beyond a message's text, read as terminators.
   function automatic logic [3:0] rom_char(input int sel, input int idx);
      logic [3:0] c;
      c = CH_BLANK;
      case (sel)
         0: begin
            case (idx)
               0:       c = CH_H;
               1:       c = CH_E;
               2:       c = CH_L;
               3:       c = CH_L;
               4:       c = CH_O;
               default: c = CH_BLANK;
            endcase
         end
         1: begin
            case (idx)
               0:       c = CH_P;
               1:       c = CH_R;
               2:       c = CH_O;
               3:       c = CH_G;
               default: c = CH_BLANK;
            endcase
         end
         default: c = CH_BLANK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Playback prescaler: counts 0..P-1 with P=(speed+1)*DIV_BASE, ticking on P-1.
// The period is re-sampled only on reload, so speed changes never cut a dwell short.
module seg7_tick_gen #(
   parameter int DIV_BASE = 4,
   parameter int PRE_W    = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic [3:0] speed,
   output logic       tick
);

   logic [PRE_W-1:0] cnt_q;
   logic [PRE_W-1:0] per_q;
   logic [PRE_W-1:0] per_new;
   logic             wrap;

   always_comb begin
      per_new = PRE_W'({1'b0, speed} + 5'd1) * PRE_W'(DIV_BASE);
   end

   assign wrap = (cnt_q == per_q - PRE_W'(1));
   assign tick = wrap & ~clr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         per_q <= PRE_W'(DIV_BASE);
      end else if (clr || wrap) begin
         cnt_q <= '0;
         per_q <= per_new;
      end else begin
         cnt_q <= cnt_q + PRE_W'(1);
      end
   end

endmodule

// File: rtl/seg7_msg_player.sv
// Plays a stored message one character at a time on a single 7-segment digit,
// with blank gaps between characters, an end marker, and loop / one-shot modes.
import seg7_msg_pkg::*;

module seg7_msg_player #(
   parameter int NUM_MSGS = 2,
   parameter int MSG_LEN  = 8,
   parameter int DIV_BASE = 4,
   parameter int PRE_W    = 24,
   parameter int SEL_W    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
   parameter int IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             mode,
   input  logic [SEL_W-1:0] msg_sel,
   input  logic [3:0]       speed,
   output logic [7:0]       seg,
   output logic [IDX_W-1:0] char_idx,
   output logic             msg_done,
   output logic             busy
);

   player_state_t    state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   disp_t            disp_q, disp_d;
   logic             clr;
   logic             tick;
   logic             done_d;
   logic             active;
   logic             restart;
   logic             last_slot;
   logic [3:0]       cur_char;
   logic [3:0]       nxt_char;

   // Out-of-range selections fall back to message 0.
   function automatic int eff_sel(input logic [SEL_W-1:0] s);
      return (int'(s) < NUM_MSGS) ? int'(s) : 0;
   endfunction

   seg7_tick_gen #(
      .DIV_BASE (DIV_BASE),
      .PRE_W    (PRE_W)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .speed   (speed),
      .tick    (tick)
   );

   always_comb begin
      cur_char  = rom_char(eff_sel(sel_q), int'(idx_q));
      nxt_char  = rom_char(eff_sel(sel_q), int'(idx_q) + 1);
      last_slot = (idx_q == IDX_W'(MSG_LEN - 1)) || (nxt_char == CH_BLANK);
      active    = (state_q == ST_SHOW) || (state_q == ST_GAP) || (state_q == ST_END);
      restart   = active && (msg_sel != sel_q);
   end

   // Priority: enable low, then message restart, then tick-driven advance.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      clr     = 1'b0;
      done_d  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         clr     = 1'b1;
      end else if (state_q == ST_IDLE || restart) begin
         state_d = ST_SHOW;
         idx_d   = '0;
         sel_d   = msg_sel;
         clr     = 1'b1;
      end else begin
         case (state_q)
            ST_SHOW: begin
               if (tick) begin
                  // An empty message has nothing to gap after.
                  if (cur_char == CH_BLANK) begin
                     state_d = ST_END;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (last_slot) begin
                     state_d = ST_END;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_SHOW;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_END: begin
               if (tick) begin
                  if (mode) begin
                     state_d = ST_HOLD;
                  end else begin
                     state_d = ST_SHOW;
                     idx_d   = '0;
                  end
               end
            end
            ST_HOLD: begin
               clr = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               clr     = 1'b1;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge.
   always_comb begin
      disp_d      = '0;
      disp_d.done = done_d;
      disp_d.busy = (state_d == ST_SHOW) || (state_d == ST_GAP) || (state_d == ST_END);
      case (state_d)
         ST_SHOW: disp_d.seg = glyph(rom_char(eff_sel(sel_d), int'(idx_d)));
         ST_END:  disp_d.seg = SEG_DP;
         default: disp_d.seg = SEG_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sel_q   <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         disp_q  <= disp_d;
      end
   end

   assign seg      = disp_q.seg;
   assign msg_done = disp_q.done;
   assign busy     = disp_q.busy;
   assign char_idx = idx_q;

endmodule

// File: tb/tb_seg7_msg_player.sv
// Directed bench for seg7_msg_player: rows of {inputs, expected outputs, dwell}
// applied cycle by cycle, plus hand-written reset sequences.
module tb_seg7_msg_player;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       enable   = 1'b0;
   logic       mode     = 1'b0;
   logic [1:0] msg_sel  = 2'd0;
   logic [3:0] speed    = 4'd0;
   logic [7:0] seg;
   logic [2:0] char_idx;
   logic       msg_done;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic       en;
      logic       md;
      logic [1:0] sel;
      logic [3:0] spd;
      logic [7:0] seg;
      logic [2:0] idx;
      logic       ci;
      logic       done;
      logic       busy;
      int         cyc;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   seg7_msg_player #(
      .NUM_MSGS (3),
      .MSG_LEN  (8),
      .DIV_BASE (4),
      .PRE_W    (24)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .mode     (mode),
      .msg_sel  (msg_sel),
      .speed    (speed),
      .seg      (seg),
      .char_idx (char_idx),
      .msg_done (msg_done),
      .busy     (busy)
   );

   task automatic chk(input string name, input int row, input int act, input int exp);
      n_chk++;
      if (act != exp)
         $display("FAIL %s row %0d t=%0t: got 0x%0h want 0x%0h", name, row, $time, act, exp);
      else
         n_pass++;
   endtask

   task automatic add(input logic en, input logic md, input logic [1:0] sel,
                      input logic [3:0] spd, input logic [7:0] s, input logic [2:0] idx,
                      input logic ci, input logic done, input logic bsy, input int cyc);
      vec_t v;
      v.en = en; v.md = md; v.sel = sel; v.spd = spd; v.seg = s; v.idx = idx;
      v.ci = ci; v.done = done; v.busy = bsy; v.cyc = cyc;
      vecs.push_back(v);
   endtask

   task automatic run(input int lo, input int hi);
      for (int r = lo; r < hi; r++) begin
         enable  = vecs[r].en;
         mode    = vecs[r].md;
         msg_sel = vecs[r].sel;
         speed   = vecs[r].spd;
         for (int c = 0; c < vecs[r].cyc; c++) begin
            @(posedge clk);
            #1;
            chk("seg", r, int'(seg), int'(vecs[r].seg));
            if (vecs[r].ci) chk("char_idx", r, int'(char_idx), int'(vecs[r].idx));
            chk("msg_done", r, int'(msg_done), int'(vecs[r].done));
            chk("busy", r, int'(busy), int'(vecs[r].busy));
         end
      end
   endtask

   initial begin
      int split;
      // Loop playback of HELLO at P=4
      add(1,0,0,0, 8'h76,0,1,0,1, 4);
      add(1,0,0,0, 8'h00,0,1,0,1, 4);
      add(1,0,0,0, 8'h79,1,1,0,1, 4);
      add(1,0,0,0, 8'h00,1,1,0,1, 4);
      add(1,0,0,0, 8'h38,2,1,0,1, 4);
      add(1,0,0,0, 8'h00,2,1,0,1, 4);
      add(1,0,0,0, 8'h38,3,1,0,1, 4);
      add(1,0,0,0, 8'h00,3,1,0,1, 4);
      add(1,0,0,0, 8'h3F,4,1,0,1, 4);
      add(1,0,0,0, 8'h00,4,1,0,1, 4);
      add(1,0,0,0, 8'h80,4,1,1,1, 1);
      add(1,0,0,0, 8'h80,4,1,0,1, 3);
      add(1,0,0,0, 8'h76,0,1,0,1, 2);
      // enable low together with a msg_sel change: stop wins
      add(0,0,1,0, 8'h00,0,1,0,0, 2);
      // One-shot PROG at P=8, then HOLD until enable drops
      add(1,1,1,1, 8'h73,0,1,0,1, 8);
      add(1,1,1,1, 8'h00,0,1,0,1, 8);
      add(1,1,1,1, 8'h50,1,1,0,1, 8);
      add(1,1,1,1, 8'h00,1,1,0,1, 8);
      add(1,1,1,1, 8'h3F,2,1,0,1, 8);
      add(1,1,1,1, 8'h00,2,1,0,1, 8);
      add(1,1,1,1, 8'h3D,3,1,0,1, 8);
      add(1,1,1,1, 8'h00,3,1,0,1, 8);
      add(1,1,1,1, 8'h80,3,1,1,1, 1);
      add(1,1,1,1, 8'h80,3,1,0,1, 7);
      add(1,1,1,1, 8'h00,0,0,0,0, 20);
      add(0,1,1,1, 8'h00,0,1,0,0, 1);
      // Message switch while E is shown
      add(1,0,0,0, 8'h76,0,1,0,1, 4);
      add(1,0,0,0, 8'h00,0,1,0,1, 4);
      add(1,0,0,0, 8'h79,1,1,0,1, 2);
      add(1,0,1,0, 8'h73,0,1,0,1, 4);
      add(1,0,1,0, 8'h00,0,1,0,1, 4);
      add(1,0,1,0, 8'h50,1,1,0,1, 1);
      add(0,0,0,0, 8'h00,0,1,0,0, 1);
      // Speed 0->3 mid-dwell: current dwell stays 4, later ones 16
      add(1,0,0,0, 8'h76,0,1,0,1, 2);
      add(1,0,0,3, 8'h76,0,1,0,1, 2);
      add(1,0,0,3, 8'h00,0,1,0,1, 16);
      add(1,0,0,3, 8'h79,1,1,0,1, 16);
      add(1,0,0,3, 8'h00,1,1,0,1, 3);
      split = vecs.size();
      // Empty message 2: blank SHOW then END, looping
      add(0,0,2,0, 8'h00,0,1,0,0, 1);
      add(1,0,2,0, 8'h00,0,1,0,1, 4);
      add(1,0,2,0, 8'h80,0,1,1,1, 1);
      add(1,0,2,0, 8'h80,0,1,0,1, 3);
      add(1,0,2,0, 8'h00,0,1,0,1, 4);
      add(1,0,2,0, 8'h80,0,1,1,1, 1);

      // Reset values, checked before any clock edge
      #1;
      chk("rst_seg", -1, int'(seg), 0);
      chk("rst_idx", -1, int'(char_idx), 0);
      chk("rst_done", -1, int'(msg_done), 0);
      chk("rst_busy", -1, int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_seg", -1, int'(seg), 0);
      reset_n = 1'b1;

      run(0, split);

      // Asynchronous reset mid-GAP, between clock edges
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_seg", -2, int'(seg), 0);
      chk("async_rst_busy", -2, int'(busy), 0);
      chk("async_rst_idx", -2, int'(char_idx), 0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_seg", -2, int'(seg), 8'h76);
      chk("post_rst_busy", -2, int'(busy), 1);

      run(split, vecs.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
